// File: rtl/ysyx_22050710_mem_stage.sv
// Memory stage: accepts the execute bus, waits for the data SRAM response, aligns load data and forwards it to writeback.
// Bypass and load-pending signals go back to decode. A one-entry buffer holds a response that arrives while writeback is stalled.
module ysyx_22050710_mem_stage #(
  parameter int GPR_WD          = 64,
  parameter int GPR_ADDR_WD     = 5,
  parameter int CSR_WD          = 64,
  parameter int CSR_ADDR_WD     = 12,
  parameter int SRAM_DATA_WD    = 64,
  // The execute-bus fields below add up to 217 bits, so the bus is sized to carry all of them.
  parameter int ES_TO_MS_BUS_WD = 217,
  parameter int MS_TO_WS_BUS_WD = 147,
  parameter int BYPASS_BUS_WD   = 145
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ws_allowin,
  output logic                       o_ms_allowin,
  input  logic                       i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
  output logic                       o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
  output logic                       o_ms_to_ds_load_sel,
  output logic [BYPASS_BUS_WD-1:0]   o_ms_to_ds_bypass_bus,
  input  logic                       i_data_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]    i_data_sram_rdata
);

  typedef enum logic {WAIT, HELD} buf_state_t;

  buf_state_t                 state, state_nxt;
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] payload;
  logic [SRAM_DATA_WD-1:0]    rdata_buf;

  logic [GPR_ADDR_WD-1:0] rd;
  logic [CSR_ADDR_WD-1:0] csr;
  logic                   gpr_wen, csr_wen, mem_ren, mem_wen, csr_inst_sel;
  logic [2:0]             mem_op;
  logic [CSR_WD-1:0]      csrrdata, csr_result;
  logic [GPR_WD-1:0]      alu_result;

  assign {rd, csr, gpr_wen, csr_wen, mem_ren, mem_wen, mem_op, csr_inst_sel,
          csrrdata, alu_result, csr_result} = payload;

  logic buf_valid, mem_acc, ms_ready_go, fire, capture;

  assign buf_valid        = (state == HELD);
  assign mem_acc          = mem_ren | mem_wen;
  assign ms_ready_go      = !mem_acc || i_data_sram_data_ok || buf_valid;
  assign o_ms_allowin     = !ms_valid || (ms_ready_go && i_ws_allowin);
  assign o_ms_to_ws_valid = ms_valid && ms_ready_go;
  assign fire             = o_ms_to_ws_valid && i_ws_allowin;
  // Only a live memory op can capture, so stale responses after reset are dropped.
  assign capture          = (state == WAIT) && ms_valid && mem_acc && i_data_sram_data_ok && !i_ws_allowin;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ms_valid <= 1'b0;
    end else if (o_ms_allowin) begin
      ms_valid <= i_es_to_ms_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      payload <= '0;
    end else if (i_es_to_ms_valid && o_ms_allowin) begin
      payload <= i_es_to_ms_bus;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= WAIT;
      rdata_buf <= '0;
    end else begin
      state <= state_nxt;
      if (capture) rdata_buf <= i_data_sram_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (capture) state_nxt = HELD;
      HELD:    if (fire)    state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  logic [SRAM_DATA_WD-1:0] mem_rdata, shifted;
  logic [GPR_WD-1:0]       load_result, gpr_wdata;

  assign mem_rdata = buf_valid ? rdata_buf : i_data_sram_rdata;
  assign shifted   = mem_rdata >> {alu_result[2:0], 3'b000};

  always_comb begin
    load_result = '0;
    case (mem_op)
      3'b000:  load_result = {{(GPR_WD-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{(GPR_WD-8){1'b0}}, shifted[7:0]};
      3'b010:  load_result = {{(GPR_WD-16){shifted[15]}}, shifted[15:0]};
      3'b011:  load_result = {{(GPR_WD-16){1'b0}}, shifted[15:0]};
      3'b100:  load_result = {{(GPR_WD-32){shifted[31]}}, shifted[31:0]};
      3'b101:  load_result = {{(GPR_WD-32){1'b0}}, shifted[31:0]};
      3'b110:  load_result = shifted[GPR_WD-1:0];
      default: load_result = '0;
    endcase
  end

  assign gpr_wdata = mem_ren      ? load_result :
                     csr_inst_sel ? csrrdata    : alu_result;

  assign o_ms_to_ws_bus      = {rd, csr, gpr_wen, csr_wen, gpr_wdata, csr_result};
  assign o_ms_to_ds_load_sel = ms_valid && mem_ren && !ms_ready_go;

  logic byp_en;
  assign byp_en = ms_valid && ms_ready_go && !mem_wen;

  assign o_ms_to_ds_bypass_bus = {
    (byp_en && gpr_wen) ? rd         : {GPR_ADDR_WD{1'b0}},
    (byp_en && gpr_wen) ? gpr_wdata  : {GPR_WD{1'b0}},
    (byp_en && csr_wen) ? csr        : {CSR_ADDR_WD{1'b0}},
    (byp_en && csr_wen) ? csr_result : {CSR_WD{1'b0}}
  };

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Directed bench for the memory stage: a vector table for writeback/load alignment plus
// hand-written sequences for multi-cycle waits, stall buffering, ordering and reset.
module tb_ysyx_22050710_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_valid;
  logic [216:0] es_bus;
  logic         ws_valid;
  logic [146:0] ws_bus;
  logic         load_sel;
  logic [144:0] byp_bus;
  logic         data_ok;
  logic [63:0]  rdata;

  int checks = 0;
  int errors = 0;
  logic [63:0] fired_q[$];

  always #5 clk = ~clk;

  ysyx_22050710_mem_stage dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_ws_allowin          (ws_allowin),
    .o_ms_allowin          (ms_allowin),
    .i_es_to_ms_valid      (es_valid),
    .i_es_to_ms_bus        (es_bus),
    .o_ms_to_ws_valid      (ws_valid),
    .o_ms_to_ws_bus        (ws_bus),
    .o_ms_to_ds_load_sel   (load_sel),
    .o_ms_to_ds_bypass_bus (byp_bus),
    .i_data_sram_data_ok   (data_ok),
    .i_data_sram_rdata     (rdata)
  );

  typedef struct {
    logic        ren, wen, sel, gwen, cwen;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [63:0] alu, csrr, csrres, rdata, exp_wdata;
  } vec_t;

  vec_t vecs[13];

  // Inputs hold steady from negedge to the next posedge, so sampling here sees what the edge sees.
  always begin
    @(negedge clk);
    #2;
    if (!rst && ws_valid && ws_allowin) fired_q.push_back(ws_bus[127:64]);
  end

  function automatic logic [216:0] pack(vec_t v);
    return {v.rd, v.csr, v.gwen, v.cwen, v.ren, v.wen, v.op, v.sel, v.csrr, v.alu, v.csrres};
  endfunction

  function automatic vec_t mk(logic ren, logic wen, logic [2:0] op, logic sel, logic gwen, logic cwen,
                              logic [4:0] rd, logic [11:0] csr, logic [63:0] alu, logic [63:0] csrr,
                              logic [63:0] csrres, logic [63:0] rd_data, logic [63:0] exp);
    vec_t v;
    v.ren = ren; v.wen = wen; v.op = op; v.sel = sel; v.gwen = gwen; v.cwen = cwen;
    v.rd = rd; v.csr = csr; v.alu = alu; v.csrr = csrr; v.csrres = csrres;
    v.rdata = rd_data; v.exp_wdata = exp;
    return v;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t alu_vec(logic [4:0] rd, logic [63:0] alu);
    return mk(0, 0, 3'b000, 0, 1, 0, rd, 12'h0, alu, 64'h0, 64'h0, 64'h0, alu);
  endfunction

  function automatic vec_t ld_vec(logic [4:0] rd, logic [63:0] rd_data);
    return mk(1, 0, 3'b110, 0, 1, 0, rd, 12'h0, 64'h1000, 64'h0, 64'h0, rd_data, rd_data);
  endfunction

  initial begin
    logic [144:0] exp_byp;
    int fires_before;

    vecs[0]  = mk(0, 0, 3'b000, 0, 1, 0, 5'd5,  12'h000, 64'h1234, 64'h0, 64'h0, 64'h0, 64'h1234);
    vecs[1]  = mk(0, 0, 3'b000, 1, 1, 1, 5'd9,  12'h305, 64'h55, 64'hDEAD_BEEF_0000_0001,
                  64'hCAFE_0000_0000_0002, 64'h0, 64'hDEAD_BEEF_0000_0001);
    vecs[2]  = mk(1, 0, 3'b000, 0, 1, 0, 5'd1,  12'h0, 64'h3, 64'h0, 64'h0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
    vecs[3]  = mk(1, 0, 3'b001, 0, 1, 0, 5'd2,  12'h0, 64'h3, 64'h0, 64'h0, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
    vecs[4]  = mk(1, 0, 3'b010, 0, 1, 0, 5'd3,  12'h0, 64'h2, 64'h0, 64'h0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF);
    vecs[5]  = mk(1, 0, 3'b011, 0, 1, 0, 5'd4,  12'h0, 64'h2, 64'h0, 64'h0, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_80FF);
    vecs[6]  = mk(1, 0, 3'b100, 0, 1, 0, 5'd6,  12'h0, 64'h4, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    vecs[7]  = mk(1, 0, 3'b101, 0, 1, 0, 5'd7,  12'h0, 64'h4, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    vecs[8]  = mk(1, 0, 3'b110, 0, 1, 0, 5'd8,  12'h0, 64'h0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    vecs[9]  = mk(1, 0, 3'b111, 0, 1, 0, 5'd10, 12'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    vecs[10] = mk(1, 0, 3'b000, 0, 1, 0, 5'd11, 12'h0, 64'h7, 64'h0, 64'h0, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F);
    vecs[11] = mk(1, 0, 3'b010, 0, 0, 0, 5'd12, 12'h0, 64'h6, 64'h0, 64'h0, 64'hFFFE_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE);
    vecs[12] = mk(0, 1, 3'b110, 0, 0, 0, 5'd13, 12'h0, 64'h2000, 64'h0, 64'h0, 64'h0, 64'h2000);

    rst = 1'b1; ws_allowin = 1'b1; es_valid = 1'b0; es_bus = '0; data_ok = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ws_valid", ws_valid, 0);
    check("reset_allowin",  ms_allowin, 1);
    check("reset_load_sel", load_sel, 0);
    check("reset_bypass",   byp_bus, 0);
    @(negedge clk); rst = 1'b0;

    // Vector table: entry cycle, then response (if any) on the next cycle with writeback ready.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      es_valid = 1'b1; es_bus = pack(vecs[i]); data_ok = 1'b0; ws_allowin = 1'b1;
      @(negedge clk);
      es_valid = 1'b0; data_ok = 1'b1; rdata = vecs[i].rdata;
      #1;
      exp_byp = '0;
      if (!vecs[i].wen) begin
        if (vecs[i].gwen) exp_byp[144:76] = {vecs[i].rd, vecs[i].exp_wdata};
        if (vecs[i].cwen) exp_byp[75:0]   = {vecs[i].csr, vecs[i].csrres};
      end
      check($sformatf("vec%0d_valid", i), ws_valid, 1);
      check($sformatf("vec%0d_ws_bus", i), ws_bus,
            {vecs[i].rd, vecs[i].csr, vecs[i].gwen, vecs[i].cwen, vecs[i].exp_wdata, vecs[i].csrres});
      check($sformatf("vec%0d_bypass", i), byp_bus, exp_byp);
      check($sformatf("vec%0d_load_sel", i), load_sel, 0);
    end
    @(negedge clk); data_ok = 1'b0;

    // lb with data_ok two cycles after entry.
    @(negedge clk); es_valid = 1'b1; es_bus = pack(vecs[2]); rdata = 64'h0;
    @(negedge clk); es_valid = 1'b0; #1;
    check("lb_wait1_load_sel", load_sel, 1);
    check("lb_wait1_valid", ws_valid, 0);
    check("lb_wait1_bypass", byp_bus, 0);
    @(negedge clk); #1;
    check("lb_wait2_load_sel", load_sel, 1);
    check("lb_wait2_allowin", ms_allowin, 0);
    @(negedge clk); data_ok = 1'b1; rdata = 64'h0000_0000_80FF_0000; #1;
    check("lb_done_load_sel", load_sel, 0);
    check("lb_done_valid", ws_valid, 1);
    check("lb_done_wdata", ws_bus[127:64], 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk); data_ok = 1'b0; #1;
    check("lb_after_valid", ws_valid, 0);

    // ld response arrives under writeback stall; it must be buffered and fire once.
    fires_before = fired_q.size();
    @(negedge clk); es_valid = 1'b1; es_bus = pack(ld_vec(5'd14, 64'h0)); ws_allowin = 1'b0;
    @(negedge clk); es_valid = 1'b0; data_ok = 1'b1; rdata = 64'hA5A5_0000_1111_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); data_ok = 1'b0; rdata = 64'h5555_6666_7777_8888 + 64'(c); #1;
      check($sformatf("hold%0d_valid", c), ws_valid, 1);
      check($sformatf("hold%0d_allowin", c), ms_allowin, 0);
      check($sformatf("hold%0d_wdata", c), ws_bus[127:64], 64'hA5A5_0000_1111_2222);
    end
    @(negedge clk); ws_allowin = 1'b1; #1;
    check("hold_release_wdata", ws_bus[127:64], 64'hA5A5_0000_1111_2222);
    check("hold_release_allowin", ms_allowin, 1);
    @(negedge clk); #1;
    check("hold_after_valid", ws_valid, 0);
    check("hold_fire_count", fired_q.size() - fires_before, 1);

    // ALU, ld (data_ok one cycle late), ALU back to back.
    fired_q.delete();
    @(negedge clk); es_valid = 1'b1; es_bus = pack(alu_vec(5'd15, 64'h11));
    @(negedge clk); es_bus = pack(ld_vec(5'd16, 64'h0)); #1;
    check("b2b_alu1_valid", ws_valid, 1);
    check("b2b_alu1_allowin", ms_allowin, 1);
    @(negedge clk); es_bus = pack(alu_vec(5'd17, 64'h33)); #1;
    check("b2b_ld_wait_valid", ws_valid, 0);
    check("b2b_ld_wait_allowin", ms_allowin, 0);
    @(negedge clk); data_ok = 1'b1; rdata = 64'h22; #1;
    check("b2b_ld_done_valid", ws_valid, 1);
    check("b2b_ld_bypass", byp_bus[144:76], {5'd16, 64'h22});
    @(negedge clk); es_valid = 1'b0; data_ok = 1'b0; rdata = 64'h0; #1;
    check("b2b_alu2_valid", ws_valid, 1);
    @(negedge clk); #1;
    check("b2b_idle_valid", ws_valid, 0);
    check("b2b_count", fired_q.size(), 3);
    if (fired_q.size() == 3) begin
      check("b2b_order0", fired_q[0], 64'h11);
      check("b2b_order1", fired_q[1], 64'h22);
      check("b2b_order2", fired_q[2], 64'h33);
    end

    // Reset during a load wait, then a stray response.
    fired_q.delete();
    @(negedge clk); es_valid = 1'b1; es_bus = pack(ld_vec(5'd18, 64'h0));
    @(negedge clk); es_valid = 1'b0; #1;
    check("rst_pre_load_sel", load_sel, 1);
    rst = 1'b1; #1;
    check("rst_mid_load_sel", load_sel, 0);
    check("rst_mid_allowin", ms_allowin, 1);
    check("rst_mid_bypass", byp_bus, 0);
    @(negedge clk); rst = 1'b0; data_ok = 1'b1; rdata = 64'hBAD0_BAD0_BAD0_BAD0; ws_allowin = 1'b0; #1;
    check("rst_stray_valid", ws_valid, 0);
    check("rst_stray_allowin", ms_allowin, 1);
    check("rst_stray_ws_bus", ws_bus, 0);
    @(negedge clk); data_ok = 1'b0; ws_allowin = 1'b1; #1;
    check("rst_after_allowin", ms_allowin, 1);
    check("rst_after_valid", ws_valid, 0);
    @(negedge clk); es_valid = 1'b1; es_bus = pack(alu_vec(5'd19, 64'h99));
    @(negedge clk); es_valid = 1'b0; #1;
    check("rst_recover_wdata", ws_bus[127:64], 64'h99);
    @(negedge clk); #1;
    check("rst_fire_count", fired_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
